// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state enum, sizes and golden model for the 4-bit Addsub checker
package addsub_pkg;
  localparam int AW = 4;
  localparam int NVEC = 1 << (2 * AW + 1);
  localparam int CNTW = 2 * AW + 2;
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  function automatic logic [AW+1:0] addsub_golden(input logic s, input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW-1:0] bx;
    logic [AW:0] sum;
    bx = b ^ {AW{s}};
    sum = {1'b0, a} + {1'b0, bx} + {{AW{1'b0}}, s};
    // subtract reports borrow, which is the inverted carry out
    return {s ? ~sum[AW] : sum[AW], (a[AW-1] == bx[AW-1]) && (sum[AW-1] != a[AW-1]), sum[AW-1:0]};
  endfunction
endpackage

// File: rtl/addsub_golden_model.sv
// addsub_golden_model: combinational wrapper returning {uov, sov, F} for the current vector
module addsub_golden_model
  import addsub_pkg::*;
#(
  parameter int W = AW
) (
  input  logic         s,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W+1:0] expected
);
  assign expected = addsub_golden(s, a, b);
endmodule

// File: rtl/addsub_checker.sv
// addsub_checker: exhaustive {S,A,B} sweep of an Addsub DUT with error count and first-failure capture
module addsub_checker
  import addsub_pkg::*;
#(
  parameter int W = AW,
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           S,
  output logic [W-1:0]   A,
  output logic [W-1:0]   B,
  input  logic [W-1:0]   F,
  input  logic           Unsigned_Overflow,
  input  logic           Signed_Overflow,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W+1:0] err_count,
  output logic           fail_valid,
  output logic [2*W:0]   fail_vec,
  output logic [W+1:0]   fail_got
);
  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);
  localparam logic [2*W:0] LAST = '1;
  state_t state, state_n;
  logic [2*W:0] idx, idx_n, fail_vec_n;
  logic [3:0] cnt, cnt_n;
  logic [2*W+1:0] err_n;
  logic [W+1:0] expected, got, fail_got_n;
  logic busy_n, done_n, pass_n, fail_valid_n, mismatch;
  assign {S, A, B} = idx;
  assign got = {Unsigned_Overflow, Signed_Overflow, F};
  // case inequality so X/Z from the DUT counts as a failure in simulation
  assign mismatch = got !== expected;
  addsub_golden_model #(.W(W)) u_golden (
    .s(S),
    .a(A),
    .b(B),
    .expected(expected)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    busy_n = busy;
    done_n = done;
    pass_n = pass;
    err_n = err_count;
    fail_valid_n = fail_valid;
    fail_vec_n = fail_vec;
    fail_got_n = fail_got;
    case (state)
      WAIT: begin
        if (cnt == '0) state_n = CHECK;
        else cnt_n = cnt - 1'b1;
      end
      CHECK: begin
        if (mismatch) begin
          err_n = err_count + {{(2*W+1){1'b0}}, ~&err_count};
          if (!fail_valid) begin
            fail_valid_n = 1'b1;
            fail_vec_n = idx;
            fail_got_n = got;
          end
        end
        if (idx == LAST) begin
          state_n = DONE;
          busy_n = 1'b0;
          done_n = 1'b1;
          pass_n = err_n == '0;
        end else begin
          state_n = WAIT;
          idx_n = idx + 1'b1;
          cnt_n = RELOAD;
        end
      end
      default: if (start) begin
        state_n = WAIT;
        idx_n = '0;
        cnt_n = RELOAD;
        busy_n = 1'b1;
        done_n = 1'b0;
        pass_n = 1'b0;
        err_n = '0;
        fail_valid_n = 1'b0;
        fail_vec_n = '0;
        fail_got_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      fail_valid <= 1'b0;
      fail_vec <= '0;
      fail_got <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      busy <= busy_n;
      done <= done_n;
      pass <= pass_n;
      err_count <= err_n;
      fail_valid <= fail_valid_n;
      fail_vec <= fail_vec_n;
      fail_got <= fail_got_n;
    end
endmodule

// File: tb/tb_addsub_checker.sv
// tb_addsub_checker: sweeps against a reference Addsub with selectable faults, scoreboarded on done
module tb_addsub_checker;
  logic clk = 0, rst = 1, start = 0;
  logic S, uov_d, sov_d, busy, done, pass, fail_valid;
  logic [3:0] A, B, f_d;
  logic [9:0] err_count;
  logic [8:0] fail_vec;
  logic [5:0] fail_got;
  int fault = 0, cyc = 0, start_edge = 0, checks = 0, errors = 0;
  logic done_q = 0;
  typedef struct {
    int lat;
    logic [9:0] errs;
    logic ps;
    logic fv;
    logic [8:0] vec;
    logic [5:0] got;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_checker dut (
    .clk(clk), .rst(rst), .start(start), .S(S), .A(A), .B(B), .F(f_d),
    .Unsigned_Overflow(uov_d), .Signed_Overflow(sov_d), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec),
    .fail_got(fail_got)
  );

  logic [4:0] usum;
  int sr;
  always_comb begin
    usum = S ? {1'b0, A} - {1'b0, B} : {1'b0, A} + {1'b0, B};
    sr = S ? int'($signed(A)) - int'($signed(B)) : int'($signed(A)) + int'($signed(B));
    f_d = usum[3:0];
    uov_d = S ? (A < B) : usum[4];
    sov_d = (sr > 7) || (sr < -8);
    if (fault == 1) f_d[0] = 1'b0;
    if (fault == 2) sov_d = 1'b0;
    if (fault == 3 && S) uov_d = !(A < B);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("done_latency", cyc - start_edge, e.lat);
        chk("err_count", err_count, e.errs);
        chk("pass", pass, e.ps);
        chk("fail_valid", fail_valid, e.fv);
        chk("fail_vec", fail_vec, e.vec);
        chk("fail_got", fail_got, e.got);
        chk("busy_at_done", busy, 0);
      end
    end
    done_q = done;
  end

  task automatic sweep(input int f, input logic [9:0] errs, input logic ps, input logic fv,
                       input logic [8:0] vec, input logic [5:0] got, input int poke);
    fault = f;
    q.push_back('{1536, errs, ps, fv, vec, got});
    start_edge = cyc + 1;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err_count, 0);
    chk("start_fv_clr", fail_valid, 0);
    for (int i = 1; i < 4000 && q.size() != 0; i++) begin
      start = (i == poke);
      @(negedge clk);
    end
    start = 0;
    chk("sweep_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_sab"}, {S, A, B}, 0);
    chk({nm, "_flags"}, {busy, done, pass, fail_valid}, 0);
    chk({nm, "_err"}, err_count, 0);
    chk({nm, "_fvec"}, fail_vec, 0);
    chk({nm, "_fgot"}, fail_got, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    @(negedge clk);
    sweep(0, 10'd0, 1, 0, 9'd0, 6'd0, -1);
    sweep(1, 10'd256, 0, 1, 9'b0_0000_0001, 6'b00_0000, -1);
    sweep(2, 10'd128, 0, 1, 9'b0_0001_0111, 6'b00_1000, -1);
    sweep(3, 10'd256, 0, 1, 9'b1_0000_0000, 6'b10_0000, -1);
    fault = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (699) @(negedge clk);
    chk("mid_sweep_errs_nonzero", err_count != 0, 1);
    #2 rst = 1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    sweep(0, 10'd0, 1, 0, 9'd0, 6'd0, -1);
    sweep(0, 10'd0, 1, 0, 9'd0, 6'd0, 100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
